// File: rtl/fpu_unpack_hs.sv
// fpu_unpack_hs -- first FPU pipeline stage (unpack + classify + order).
//
// Splits two IEEE-754-style operands into sign / exponent / mantissa,
// classifies each as {nan, inf, zero, subnormal}, orders add/sub operands
// by magnitude, computes the alignment shift and flags invalid operations.
// The result is registered behind a one-deep valid/ready output register.
//
// Handshake: a transfer happens on a rising clk edge when valid & ready are
// both high on that side. in_ready = ~out_valid | out_ready, so the register
// refills on the same edge it drains and no input is ever dropped. While
// out_valid & ~out_ready, every output is held stable.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_operand_a/_b       raw operands (W bits)
//   in_operator           00 add, 01 sub, 10 mul, 11 div
//   out_valid/out_ready   output handshake
//   sign_*/exponent_*/mantissa_*/class_*  per-operand fields (1 = larger for add/sub)
//   exp_diff              exponent_1 - exponent_2 (add/sub), else 0
//   nan_result            result is NaN regardless of later datapath
//   operator              registered copy of in_operator
module fpu_unpack_hs #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_operand_a,
  input  logic [W-1:0]     in_operand_b,
  input  logic [1:0]       in_operator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_1,
  output logic             sign_2,
  output logic [EXP_W-1:0] exponent_1,
  output logic [EXP_W-1:0] exponent_2,
  output logic [MAN_W:0]   mantissa_1,
  output logic [MAN_W:0]   mantissa_2,
  output logic [EXP_W-1:0] exp_diff,
  output logic [3:0]       class_1,
  output logic [3:0]       class_2,
  output logic             nan_result,
  output logic [1:0]       operator
);

  localparam logic [1:0]       OP_SUB  = 2'b01;
  localparam logic [1:0]       OP_MUL  = 2'b10;
  localparam logic [1:0]       OP_DIV  = 2'b11;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  // Class vector bit positions: {nan, inf, zero, subnormal}
  localparam int C_NAN = 3;
  localparam int C_INF = 2;
  localparam int C_ZER = 1;

  // ---------------- field decode ----------------
  logic             sign_a, sign_b_eff;
  logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic [MAN_W:0]   man_a, man_b;
  logic [3:0]       cls_a, cls_b;
  logic             is_addsub, swap;

  assign sign_a = in_operand_a[W-1];
  assign exp_a  = in_operand_a[W-2 -: EXP_W];
  assign exp_b  = in_operand_b[W-2 -: EXP_W];
  assign frac_a = in_operand_a[MAN_W-1:0];
  assign frac_b = in_operand_b[MAN_W-1:0];

  // Zero/subnormal operands use effective exponent 1 with hidden bit 0 so the
  // aligner treats them on the same scale as the smallest normal.
  assign eff_a = (exp_a == '0) ? EXP_ONE : exp_a;
  assign eff_b = (exp_b == '0) ? EXP_ONE : exp_b;
  assign man_a = {exp_a != '0, frac_a};
  assign man_b = {exp_b != '0, frac_b};

  assign cls_a = {(exp_a == '1) && (frac_a != '0), (exp_a == '1) && (frac_a == '0),
                  (exp_a == '0) && (frac_a == '0), (exp_a == '0) && (frac_a != '0)};
  assign cls_b = {(exp_b == '1) && (frac_b != '0), (exp_b == '1) && (frac_b == '0),
                  (exp_b == '0) && (frac_b == '0), (exp_b == '0) && (frac_b != '0)};

  assign is_addsub  = ~in_operator[1];
  // Subtraction is an addition of -B; mul/div keep B's sign untouched.
  assign sign_b_eff = in_operand_b[W-1] ^ (in_operator == OP_SUB);
  // The raw {exp,frac} field compares as an unsigned integer in magnitude order.
  assign swap = is_addsub && (in_operand_a[W-2:0] < in_operand_b[W-2:0]);

  // ---------------- next-state data ----------------
  logic             s1_d, s2_d, nan_d;
  logic [EXP_W-1:0] e1_d, e2_d, ediff_d;
  logic [MAN_W:0]   m1_d, m2_d;
  logic [3:0]       c1_d, c2_d;

  always_comb begin
    s1_d = swap ? sign_b_eff : sign_a;
    s2_d = swap ? sign_a     : sign_b_eff;
    e1_d = swap ? eff_b      : eff_a;
    e2_d = swap ? eff_a      : eff_b;
    m1_d = swap ? man_b      : man_a;
    m2_d = swap ? man_a      : man_b;
    c1_d = swap ? cls_b      : cls_a;
    c2_d = swap ? cls_a      : cls_b;
    // Operand 1 has the larger raw magnitude, hence never a smaller effective exponent.
    ediff_d = is_addsub ? (e1_d - e2_d) : '0;

    nan_d = cls_a[C_NAN] | cls_b[C_NAN];
    if (is_addsub && cls_a[C_INF] && cls_b[C_INF] && (sign_a != sign_b_eff))
      nan_d = 1'b1;
    if ((in_operator == OP_MUL) &&
        ((cls_a[C_ZER] && cls_b[C_INF]) || (cls_a[C_INF] && cls_b[C_ZER])))
      nan_d = 1'b1;
    if ((in_operator == OP_DIV) &&
        ((cls_a[C_ZER] && cls_b[C_ZER]) || (cls_a[C_INF] && cls_b[C_INF])))
      nan_d = 1'b1;
  end

  // ---------------- output register ----------------
  logic             valid_q, s1_q, s2_q, nan_q;
  logic [EXP_W-1:0] e1_q, e2_q, ediff_q;
  logic [MAN_W:0]   m1_q, m2_q;
  logic [3:0]       c1_q, c2_q;
  logic [1:0]       op_q;
  logic             load;

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      e1_q    <= '0;
      e2_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      ediff_q <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      nan_q   <= 1'b0;
      op_q    <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      ediff_q <= ediff_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      nan_q   <= nan_d;
      op_q    <= in_operator;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign sign_1     = s1_q;
  assign sign_2     = s2_q;
  assign exponent_1 = e1_q;
  assign exponent_2 = e2_q;
  assign mantissa_1 = m1_q;
  assign mantissa_2 = m2_q;
  assign exp_diff   = ediff_q;
  assign class_1    = c1_q;
  assign class_2    = c2_q;
  assign nan_result = nan_q;
  assign operator   = op_q;

endmodule

// File: tb/tb_fpu_unpack_hs.sv
module tb_fpu_unpack_hs;

  // Packed result layout used for both instances (half precision zero-extended):
  // {s1, s2, e1[8], e2[8], m1[24], m2[24], ediff[8], c1[4], c2[4], nan, op[2]}
  localparam int EW = 85;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single precision DUT ----------------
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_operand_a, in_operand_b;
  logic [1:0]  in_operator, operator;
  logic        sign_1, sign_2, nan_result;
  logic [7:0]  exponent_1, exponent_2, exp_diff;
  logic [23:0] mantissa_1, mantissa_2;
  logic [3:0]  class_1, class_2;

  fpu_unpack_hs dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_operand_a(in_operand_a), .in_operand_b(in_operand_b), .in_operator(in_operator),
    .out_valid(out_valid), .out_ready(out_ready), .sign_1(sign_1), .sign_2(sign_2),
    .exponent_1(exponent_1), .exponent_2(exponent_2), .mantissa_1(mantissa_1),
    .mantissa_2(mantissa_2), .exp_diff(exp_diff), .class_1(class_1), .class_2(class_2),
    .nan_result(nan_result), .operator(operator)
  );

  // ---------------- half precision DUT ----------------
  logic        h_rst_n, h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b;
  logic [1:0]  h_in_op, h_op;
  logic        h_s1, h_s2, h_nan;
  logic [4:0]  h_e1, h_e2, h_ed;
  logic [10:0] h_m1, h_m2;
  logic [3:0]  h_c1, h_c2;

  fpu_unpack_hs #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(h_rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_operand_a(h_a), .in_operand_b(h_b), .in_operator(h_in_op),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .sign_1(h_s1), .sign_2(h_s2),
    .exponent_1(h_e1), .exponent_2(h_e2), .mantissa_1(h_m1), .mantissa_2(h_m2),
    .exp_diff(h_ed), .class_1(h_c1), .class_2(h_c2), .nan_result(h_nan), .operator(h_op)
  );

  logic [EW-1:0] act_f, act_h;
  assign act_f = {sign_1, sign_2, exponent_1, exponent_2, mantissa_1, mantissa_2,
                  exp_diff, class_1, class_2, nan_result, operator};
  assign act_h = {h_s1, h_s2, 3'b0, h_e1, 3'b0, h_e2, 13'b0, h_m1, 13'b0, h_m2,
                  3'b0, h_ed, h_c1, h_c2, h_nan, h_op};

  // ---------------- reference model ----------------
  // Works from the number-format rules on plain integers for any ew/mw.
  function automatic logic [EW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input int ew, input int mw);
    logic [31:0] emax, fmask, mmask, x, ed;
    logic [31:0] e[2], f[2], eff[2], man[2], mag[2];
    logic        s[2];
    logic [3:0]  c[2];
    logic        addsub, swap, nan;
    int          i1, i2;
    emax  = (32'd1 << ew) - 32'd1;
    fmask = (32'd1 << mw) - 32'd1;
    mmask = (32'd1 << (ew + mw)) - 32'd1;
    for (int i = 0; i < 2; i++) begin
      x      = (i == 0) ? a : b;
      s[i]   = x[ew+mw];
      e[i]   = (x >> mw) & emax;
      f[i]   = x & fmask;
      mag[i] = x & mmask;
      eff[i] = (e[i] == 0) ? 32'd1 : e[i];
      man[i] = (e[i] == 0) ? f[i] : f[i] + (32'd1 << mw);
      c[i]   = {e[i] == emax && f[i] != 0, e[i] == emax && f[i] == 0,
                e[i] == 0 && f[i] == 0, e[i] == 0 && f[i] != 0};
    end
    addsub = (op == 2'd0) || (op == 2'd1);
    if (op == 2'd1) s[1] = ~s[1];
    swap = addsub && (mag[0] < mag[1]);
    i1 = swap ? 1 : 0;
    i2 = swap ? 0 : 1;
    ed = addsub ? eff[i1] - eff[i2] : 32'd0;
    nan = c[0][3] | c[1][3];
    if (addsub && c[0][2] && c[1][2] && (s[0] != s[1])) nan = 1'b1;
    if (op == 2'd2 && ((c[0][1] && c[1][2]) || (c[0][2] && c[1][1]))) nan = 1'b1;
    if (op == 2'd3 && ((c[0][1] && c[1][1]) || (c[0][2] && c[1][2]))) nan = 1'b1;
    return {s[i1], s[i2], eff[i1][7:0], eff[i2][7:0], man[i1][23:0], man[i2][23:0],
            ed[7:0], c[i1], c[i2], nan, op};
  endfunction

  // Random operand biased toward zero/subnormal/inf/NaN encodings.
  function automatic logic [31:0] rand_opnd(input int ew, input int mw);
    logic [31:0] e, f, s, emax;
    int sel;
    emax = (32'd1 << ew) - 32'd1;
    sel = $urandom_range(0, 5);
    if (sel == 0)      e = 32'd0;
    else if (sel == 1) e = emax;
    else               e = $urandom_range(1, emax - 1);
    f = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & ((32'd1 << mw) - 32'd1));
    s = $urandom_range(0, 1);
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    in_operand_a = a; in_operand_b = b; in_operator = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_h(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input logic rdy);
    @(negedge clk);
    h_in_valid = 1'b1; h_out_ready = rdy;
    h_a = a; h_b = b; h_in_op = op;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; h_rst_n = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    in_operand_a = 32'h3F800000; in_operand_b = 32'h40000000; in_operator = 2'b00;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_in_op = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    n_cmp++;
    if (act_f !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h exp 0", act_f);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; h_rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0]   ta[7], tb[7];
    logic [1:0]    top[7];
    logic [EW-1:0] te[7];
    ta[0] = 32'h3F800000; tb[0] = 32'h40000000; top[0] = 2'b00;
    te[0] = {1'b0, 1'b0, 8'h80, 8'h7F, 24'h800000, 24'h800000, 8'h01, 4'h0, 4'h0, 1'b0, 2'b00};
    ta[1] = 32'h40000000; tb[1] = 32'h40000000; top[1] = 2'b01;
    te[1] = {1'b0, 1'b1, 8'h80, 8'h80, 24'h800000, 24'h800000, 8'h00, 4'h0, 4'h0, 1'b0, 2'b01};
    ta[2] = 32'h00000001; tb[2] = 32'h00000000; top[2] = 2'b00;
    te[2] = {1'b0, 1'b0, 8'h01, 8'h01, 24'h000001, 24'h000000, 8'h00, 4'h1, 4'h2, 1'b0, 2'b00};
    ta[3] = 32'h7F800000; tb[3] = 32'h7F800000; top[3] = 2'b01;
    te[3] = {1'b0, 1'b1, 8'hFF, 8'hFF, 24'h800000, 24'h800000, 8'h00, 4'h4, 4'h4, 1'b1, 2'b01};
    ta[4] = 32'h00000000; tb[4] = 32'hFF800000; top[4] = 2'b10;
    te[4] = {1'b0, 1'b1, 8'h01, 8'hFF, 24'h000000, 24'h800000, 8'h00, 4'h2, 4'h4, 1'b1, 2'b10};
    ta[5] = 32'h7FC00000; tb[5] = 32'h3F800000; top[5] = 2'b11;
    te[5] = {1'b0, 1'b0, 8'hFF, 8'h7F, 24'hC00000, 24'h800000, 8'h00, 4'h8, 4'h0, 1'b1, 2'b11};
    ta[6] = 32'h7F800000; tb[6] = 32'h3F800000; top[6] = 2'b00;
    te[6] = {1'b0, 1'b0, 8'hFF, 8'h7F, 24'h800000, 24'h800000, 8'h80, 4'h4, 4'h0, 1'b0, 2'b00};
    for (int i = 0; i < 7; i++) begin
      drive_f(ta[i], tb[i], top[i]);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL directed%0d_valid got %b exp 1", i, out_valid);
      end
      n_cmp++;
      if (act_f !== te[i]) begin
        n_err++; $display("FAIL directed%0d_fields got %h exp %h", i, act_f, te[i]);
      end
      n_cmp++;
      if (act_f !== model(ta[i], tb[i], top[i], 8, 23)) begin
        n_err++; $display("FAIL directed%0d_model got %h exp %h", i, act_f,
                          model(ta[i], tb[i], top[i], 8, 23));
      end
    end
    @(posedge clk); #1;
  endtask

  // Randomised stream with scoreboard; out_ready forced low in [stall_lo, stall_hi].
  task automatic test_stream(input string name, input int n, input int pv, input int pr,
                             input int op_fix, input int stall_lo, input int stall_hi,
                             output int cycles);
    int sent;
    sent = 0; cycles = 0;
    while ((sent < n || exp_q.size() > 0) && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      n_cmp++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_err++; $display("FAIL %s_out_valid got %b exp %0d", name, out_valid, exp_q.size());
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        n_cmp++;
        if (act_f !== exp_q[0]) begin
          n_err++; $display("FAIL %s_data got %h exp %h", name, act_f, exp_q[0]);
        end
      end
      out_ready = (cycles >= stall_lo && cycles <= stall_hi) ? 1'b0 :
                  ($urandom_range(0, 99) < pr);
      in_operand_a = rand_opnd(8, 23);
      in_operand_b = ($urandom_range(0, 7) == 0) ? (in_operand_a ^ {$urandom_range(0, 1), 31'b0})
                                                 : rand_opnd(8, 23);
      in_operator = (op_fix < 0) ? 2'($urandom_range(0, 3)) : 2'(op_fix);
      in_valid = (sent < n) && ($urandom_range(0, 99) < pv);
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_err++; $display("FAIL %s_in_ready got %b exp %b", name, in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_operand_a, in_operand_b, in_operator, 8, 23));
        sent++;
      end
    end
    n_cmp++;
    if (cycles >= 4000) begin
      n_err++; $display("FAIL %s_timeout got %0d sent exp %0d", name, sent, n);
    end
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int cyc;
    test_stream("b2b", 8, 100, 100, -1, 0, -1, cyc);
    n_cmp++;
    if (cyc !== 9) begin
      n_err++; $display("FAIL b2b_throughput got %0d cycles exp 9", cyc);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    test_stream("bp", 4, 100, 100, 0, 2, 4, cyc);
    n_cmp++;
    if (cyc !== 8) begin
      n_err++; $display("FAIL bp_cycles got %0d exp 8", cyc);
    end
  endtask

  task automatic test_random;
    int cyc;
    test_stream("rand", 300, 70, 60, -1, 0, -1, cyc);
  endtask

  task automatic test_half;
    logic [15:0]   a, b;
    logic [1:0]    op;
    logic [EW-1:0] e;
    drive_h(16'h3C00, 16'hC000, 2'b00, 1'b1);
    e = {1'b1, 1'b0, 8'h10, 8'h0F, 24'h000400, 24'h000400, 8'h01, 4'h0, 4'h0, 1'b0, 2'b00};
    n_cmp++;
    if (h_out_valid !== 1'b1 || act_h !== e) begin
      n_err++; $display("FAIL half_add got %b/%h exp 1/%h", h_out_valid, act_h, e);
    end
    for (int i = 0; i < 40; i++) begin
      a = 16'(rand_opnd(5, 10));
      b = ($urandom_range(0, 7) == 0) ? a : 16'(rand_opnd(5, 10));
      op = 2'($urandom_range(0, 3));
      drive_h(a, b, op, 1'b1);
      e = model({16'b0, a}, {16'b0, b}, op, 5, 10);
      n_cmp++;
      if (act_h !== e) begin
        n_err++; $display("FAIL half_rand%0d got %h exp %h", i, act_h, e);
      end
    end
    // Stall, then reset while the result is held and a new input is offered.
    drive_h(16'h4200, 16'h3C00, 2'b10, 1'b0);
    n_cmp++;
    if (h_out_valid !== 1'b1 || h_in_ready !== 1'b0) begin
      n_err++; $display("FAIL half_stall got %b/%b exp 1/0", h_out_valid, h_in_ready);
    end
    @(negedge clk);
    h_rst_n = 1'b0; h_in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (h_out_valid !== 1'b0 || act_h !== '0) begin
      n_err++; $display("FAIL half_reset got %b/%h exp 0/0", h_out_valid, act_h);
    end
    @(negedge clk);
    h_rst_n = 1'b1; h_in_valid = 1'b0; h_out_ready = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_half();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
